// File: rtl/rr_mux_arbiter_4.sv
// Four-way round-robin arbiter feeding a registered output word with valid/ready handoff.
// The requester acked on the previous edge is masked out so a held request cannot win twice in a row.
//
// state | meaning
// IDLE  | no word held, out_valid low, waiting for an eligible request
// BUSY  | word held on data_out, out_valid high until accepted
module rr_mux_arbiter_4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req,
  input  logic [4*DATA_WIDTH-1:0] data_in,
  output logic [3:0]              ack,
  output logic [3:0]              grant,
  output logic [1:0]              select,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic [1:0]            rr_ptr;
  logic [3:0]            eligible;
  logic                  found;
  logic [1:0]            winner;
  logic [1:0]            idx;
  logic [DATA_WIDTH-1:0] win_word;
  logic                  capture;
  logic                  clear;
  logic                  xfer;

  assign eligible  = req & ~ack;
  assign out_valid = (state_q == BUSY);
  assign xfer      = out_valid & out_ready;

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    win_word = data_in[DATA_WIDTH-1:0];
    for (int k = 0; k < 4; k++) begin
      if (winner == 2'(k)) win_word = data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          capture = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (found) begin
            capture = 1'b1;
          end else begin
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr     <= 2'd0;
      ack        <= 4'b0000;
      grant      <= 4'b0000;
      select     <= 2'd0;
      data_out   <= '0;
      xfer_count <= 16'd0;
    end else begin
      state_q <= state_d;
      ack     <= capture ? (4'b0001 << winner) : 4'b0000;
      if (capture) begin
        data_out <= win_word;
        grant    <= 4'b0001 << winner;
        select   <= winner;
        rr_ptr   <= winner + 2'd1;
      end else if (clear) begin
        grant  <= 4'b0000;
        select <= 2'd0;
      end
      // 16-bit add wraps naturally from 0xFFFF to 0
      if (xfer) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: stimulus pushes expected words into a scoreboard,
// a negedge monitor pops one entry per accepted transfer and compares.
module tb_rr_mux_arbiter_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [1:0]  select;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_count;

  typedef struct {
    logic [7:0] data;
    logic [3:0] grant;
    logic [1:0] sel;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic sb_en = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rr_mux_arbiter_4 #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .grant      (grant),
    .select     (select),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] g, input logic [1:0] s);
    exp_t e;
    e.data  = d;
    e.grant = g;
    e.sel   = s;
    sb_q.push_back(e);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_en && rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: transfer of %0h with no expected entry at %0t", data_out, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mon_data", 32'(data_out), 32'(mon_e.data));
        chk("mon_grant", 32'(grant), 32'(mon_e.grant));
        chk("mon_select", 32'(select), 32'(mon_e.sel));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    data_in   = 32'h0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_xfer", 32'(xfer_count), 32'd0);
    end

    // single requester 2
    data_in   = {8'h00, 8'hA5, 8'h00, 8'h00};
    req       = 4'b0100;
    out_ready = 1'b1;
    push(8'hA5, 4'b0100, 2'd2);
    tick();
    chk("single_ack", 32'(ack), 32'b0100);
    chk("single_sel", 32'(select), 32'd2);
    chk("single_data", 32'(data_out), 32'hA5);
    chk("single_grant", 32'(grant), 32'b0100);
    req = 4'b0000;
    tick();
    chk("single_xfer", 32'(xfer_count), 32'd1);
    chk("single_ack_off", 32'(ack), 32'd0);
    chk("single_idle", 32'(out_valid), 32'd0);
    chk("single_grant_clr", 32'(grant), 32'd0);

    // all four requesting, back-to-back rotation from pointer 0
    reset_pulse();
    data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    req     = 4'b1111;
    push(8'h10, 4'b0001, 2'd0);
    push(8'h11, 4'b0010, 2'd1);
    push(8'h12, 4'b0100, 2'd2);
    push(8'h13, 4'b1000, 2'd3);
    push(8'h10, 4'b0001, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    req = 4'b0000;
    tick();
    chk("rr_xfer", 32'(xfer_count), 32'd5);
    chk("rr_idle", 32'(out_valid), 32'd0);

    // backpressure holds the word
    reset_pulse();
    data_in   = {8'h00, 8'h00, 8'h21, 8'h20};
    req       = 4'b0011;
    out_ready = 1'b0;
    push(8'h20, 4'b0001, 2'd0);
    push(8'h21, 4'b0010, 2'd1);
    tick();
    chk("bp_ack_first", 32'(ack), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ack_held", 32'(ack), 32'd0);
      chk("bp_grant_held", 32'(grant), 32'b0001);
      chk("bp_data_held", 32'(data_out), 32'h20);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_grant", 32'(grant), 32'b0010);
    chk("bp_next_ack", 32'(ack), 32'b0010);
    req = 4'b0000;
    tick();
    chk("bp_xfer", 32'(xfer_count), 32'd2);

    // asynchronous reset while BUSY discards the word
    data_in   = {8'h00, 8'h00, 8'h00, 8'h5A};
    req       = 4'b0001;
    out_ready = 1'b0;
    tick();
    chk("ar_data_pre", 32'(data_out), 32'h5A);
    chk("ar_valid_pre", 32'(out_valid), 32'd1);
    req = 4'b0000;
    #3 rst_n = 1'b0;
    #1;
    chk("ar_data", 32'(data_out), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_select", 32'(select), 32'd0);
    chk("ar_ack", 32'(ack), 32'd0);
    chk("ar_xfer", 32'(xfer_count), 32'd0);
    #2 rst_n = 1'b1;
    data_in   = {8'h3C, 8'h00, 8'h00, 8'h00};
    req       = 4'b1000;
    out_ready = 1'b1;
    push(8'h3C, 4'b1000, 2'd3);
    tick();
    chk("ar_post_sel", 32'(select), 32'd3);
    chk("ar_post_xfer0", 32'(xfer_count), 32'd0);
    req = 4'b0000;
    tick();
    chk("ar_post_xfer1", 32'(xfer_count), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // counter wrap: 65535 transfers then one more
    sb_en = 1'b0;
    reset_pulse();
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    req     = 4'b1111;
    repeat (65536) tick();
    chk("wrap_ffff", 32'(xfer_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(xfer_count), 32'h0000);
    req = 4'b0000;
    tick();
    chk("wrap_after", 32'(xfer_count), 32'd1);
    chk("wrap_idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
RR_MUX_ARBITER_4 -- requirements
Module: rr_mux_arbiter_4

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of each requester's data word.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request per requester; bit i = requester i.
REQ-005 Port: data_in  input  4*DATA_WIDTH  packed words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 Port: ack  output  4  one-hot, one-cycle pulse: requester i's word was captured.
REQ-007 Port: grant  output  4  one-hot owner of the word held on data_out; zero when idle.
REQ-008 Port: select  output  2  encoded index of the granted requester, for driving mux_4_to_1 select.
REQ-009 Port: data_out  output  DATA_WIDTH  captured word, registered.
REQ-010 Port: out_valid  output  1  data_out holds a word not yet accepted.
REQ-011 Port: out_ready  input  1  consumer accepts data_out when high with out_valid.
REQ-012 Port: xfer_count  output  16  number of completed output transfers.

Function
REQ-013 States SHALL be IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 Eligible set SHALL be req with the bit matching the currently asserted ack masked off.
REQ-015 Winner SHALL be the first eligible index found scanning rr_ptr, rr_ptr+1, ... modulo 4.
REQ-016 Capture event: data_out <= winner's word, grant <= one-hot(winner), select <= winner, ack <= one-hot(winner) for exactly one cycle, rr_ptr <= (winner+1) mod 4, out_valid <= 1, state <= BUSY.
REQ-017 IDLE with eligible set non-empty SHALL perform a capture on that edge; IDLE with none SHALL hold all outputs, ack=0.
REQ-018 BUSY with out_ready=0 SHALL hold data_out, grant, select, out_valid stable; ack=0 after its pulse.
REQ-019 BUSY with out_ready=1 and eligible set non-empty SHALL complete the transfer and capture the next winner on the same edge (back-to-back, one word per cycle).
REQ-020 BUSY with out_ready=1 and eligible set empty SHALL clear out_valid, grant and select to 0 and go IDLE.
REQ-021 out_ready while IDLE SHALL be ignored.
REQ-022 xfer_count SHALL increment by 1 on each edge where out_valid=1 and out_ready=1, wrapping 0xFFFF -> 0x0000.
REQ-023 rr_ptr SHALL change only on a capture; a requester SHALL wait at most 3 captures of others while its req is held.
REQ-024 req changing while BUSY SHALL not affect the held word.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, rr_ptr=0, ack=0, grant=0, select=0, data_out=0, out_valid=0, xfer_count=0, regardless of clk.
REQ-026 Reset asserted while BUSY SHALL discard the held word with no transfer counted; first capture after release SHALL use rr_ptr=0.

Verification
REQ-027 Reset release, req=4'b0000 for 5 cycles -> out_valid=0, grant=0, ack=0, xfer_count=0 throughout.
REQ-028 req=4'b0100, word2=8'hA5, out_ready=1 -> next edge: data_out=8'hA5, select=2, grant=4'b0100, ack=4'b0100 one cycle; following edge xfer_count=1.
REQ-029 req=4'b1111 held, out_ready=1, words 8'h10..8'h13 -> grants in order 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-030 req=4'b0011, out_ready=0 for 4 cycles then 1 -> data_out/grant=4'b0001 stable for 4 cycles, ack only first cycle; then requester 1 granted.
REQ-031 Assert rst_n low mid-cycle while BUSY with data_out=8'h5A -> outputs zero without a clk edge; after release req=4'b1000 -> select=3, xfer_count counts from 0.
REQ-032 Preload 65535 transfers (or force counter to 0xFFFF) then one transfer -> xfer_count=0x0000.
